// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and baud divisor helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_e;

   localparam int unsigned OVERSAMPLE = 16;
   localparam logic [3:0]  MID_TICK   = 4'd7;
   localparam logic [3:0]  LAST_TICK  = 4'd15;

   function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick: one-clk pulse every DIVISOR clocks, never realigned.
module baud_tick_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 19200
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int unsigned   DIVISOR = calc_divisor(CLK_FREQ, BAUD);
   localparam int unsigned   CW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [CW-1:0] LAST    = CW'(DIVISOR - 1);

   if (DIVISOR < 2) begin : g_div_check
      $error("baud_tick_gen: CLK_FREQ/(BAUD*16) must be at least 2");
   end

   logic [CW-1:0] cnt_q, cnt_d;

   assign o_tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = o_tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-FF input synchronizer, 16x oversampled mid-bit FSM, registered strobes.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 19200,
   parameter int unsigned DBIT     = 8,
   parameter int unsigned SB_TICK  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_rx,
   output logic [DBIT-1:0] o_data,
   output logic            o_rx_done,
   output logic            o_frame_err
);

   localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

   if (SB_TICK < OVERSAMPLE / 2) begin : g_sb_check
      $error("uart_rx: SB_TICK too short for a mid stop-bit sample");
   end

   logic [1:0]      sync_q;
   logic            rx_s;
   logic            tick;
   rx_state_e       state_q, state_d;
   logic [3:0]      s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] sh_q, sh_d;
   logic [DBIT-1:0] data_q, data_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;

   baud_tick_gen #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .o_tick (tick)
   );

   assign rx_s = sync_q[1];

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      sh_d    = sh_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               s_d     = '0;
            end
         end
         START: begin
            if (tick) begin
               if (s_q == MID_TICK) begin
                  state_d = rx_s ? IDLE : DATA;
                  s_d     = '0;
                  n_d     = '0;
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (s_q == LAST_TICK) begin
                  s_d  = '0;
                  sh_d = {rx_s, sh_q[DBIT-1:1]};
                  if (n_q == NW'(DBIT - 1)) state_d = STOP;
                  else                      n_d     = n_q + 1'b1;
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         STOP: begin
            // s restarted at the middle of the last data bit, so a full
            // 16-tick count lands in the middle of the stop bit.
            if (tick) begin
               if (s_q == LAST_TICK) begin
                  state_d = IDLE;
                  s_d     = '0;
                  if (rx_s) begin
                     data_d = sh_q;
                     done_d = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  s_d = s_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '1;
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         sh_q    <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], i_rx};
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

   assign o_data      = data_q;
   assign o_rx_done   = done_q;
   assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a byte-level model.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ = 1_600_000;
   localparam int unsigned BAUD     = 10_000;
   localparam int          BIT_CLK  = 160;
   // Start edge is not aligned to the tick phase, so allow one tick below nominal 1523.
   localparam int          LAT_MIN  = 1513;
   localparam int          LAT_MAX  = 1540;
   // Bad stop bit is held low until this many clocks after the start edge.
   localparam int          BAD_STOP_END = 1560;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_rx_done;
   logic       o_frame_err;

   uart_rx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .DBIT     (8),
      .SB_TICK  (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx        (i_rx),
      .o_data      (o_data),
      .o_rx_done   (o_rx_done),
      .o_frame_err (o_frame_err)
   );

   always #5 clk = ~clk;

   int     vectors     = 0;
   int     miscompares = 0;
   longint cyc         = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] got_q[$];
   longint     got_cyc[$];
   int         ferr_cnt = 0;
   int         overlap  = 0;
   int         wide     = 0;
   logic       prev_done = 1'b0;
   logic       prev_ferr = 1'b0;

   always @(negedge clk) begin
      if (o_rx_done) begin
         got_q.push_back(o_data);
         got_cyc.push_back(cyc);
      end
      if (o_frame_err) ferr_cnt++;
      if (o_rx_done && o_frame_err) overlap++;
      if ((o_rx_done && prev_done) || (o_frame_err && prev_ferr)) wide++;
      prev_done = o_rx_done;
      prev_ferr = o_frame_err;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mon();
      got_q.delete();
      got_cyc.delete();
      ferr_cnt = 0;
   endtask

   task automatic send_frame(input logic [7:0] b, input int bclk,
                             input logic stop_v, input int stop_len);
      i_rx = 1'b0;
      idle(bclk);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         idle(bclk);
      end
      i_rx = stop_v;
      idle(stop_len);
      i_rx = 1'b1;
   endtask

   function automatic logic [7:0] got_at(input int idx);
      logic [7:0] v;
      v = 8'hxx;
      if (idx < got_q.size()) v = got_q[idx];
      return v;
   endfunction

   task automatic check_count(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      vectors++;
      if (o_data !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_data: got %h expected 00", o_data);
      end
      vectors++;
      if (o_rx_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_done: got %b expected 0", o_rx_done);
      end
      vectors++;
      if (o_frame_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ferr: got %b expected 0", o_frame_err);
      end
   endtask

   task automatic test_single();
      longint t0;
      int     lat;
      clear_mon();
      t0 = cyc;
      send_frame(8'h01, BIT_CLK, 1'b1, BIT_CLK);
      idle(300);
      check_count("single_done_count", got_q.size(), 1);
      vectors++;
      if (got_at(0) !== 8'h01) begin
         miscompares++;
         $display("FAIL single_data: got %h expected 01", got_at(0));
      end
      check_count("single_ferr_count", ferr_cnt, 0);
      lat = (got_cyc.size() > 0) ? int'(got_cyc[0] - t0) : -1;
      vectors++;
      if (lat < LAT_MIN || lat > LAT_MAX) begin
         miscompares++;
         $display("FAIL single_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [4];
      exp = '{8'h80, 8'h40, 8'hC0, 8'h20};
      clear_mon();
      for (int i = 0; i < 4; i++) send_frame(exp[i], BIT_CLK, 1'b1, BIT_CLK);
      idle(300);
      check_count("b2b_done_count", got_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (got_at(i) !== exp[i]) begin
            miscompares++;
            $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_at(i), exp[i]);
         end
      end
      check_count("b2b_ferr_count", ferr_cnt, 0);
   endtask

   task automatic test_glitch();
      clear_mon();
      i_rx = 1'b0;
      idle(40);
      i_rx = 1'b1;
      idle(300);
      check_count("glitch_done_count", got_q.size(), 0);
      check_count("glitch_ferr_count", ferr_cnt, 0);
      send_frame(8'h5A, BIT_CLK, 1'b1, BIT_CLK);
      idle(300);
      check_count("glitch_next_count", got_q.size(), 1);
      vectors++;
      if (got_at(0) !== 8'h5A) begin
         miscompares++;
         $display("FAIL glitch_next_data: got %h expected 5a", got_at(0));
      end
   endtask

   task automatic test_frame_error();
      clear_mon();
      send_frame(8'h33, BIT_CLK, 1'b1, BIT_CLK);
      idle(200);
      send_frame(8'h00, BIT_CLK, 1'b0, BAD_STOP_END - 9 * BIT_CLK);
      idle(400);
      check_count("ferr_count", ferr_cnt, 1);
      check_count("ferr_done_count", got_q.size(), 1);
      vectors++;
      if (o_data !== 8'h33) begin
         miscompares++;
         $display("FAIL ferr_data_held: got %h expected 33", o_data);
      end
   endtask

   task automatic test_reset_midframe();
      i_rx = 1'b0;
      idle(BIT_CLK);
      i_rx = 1'b1;
      idle(4 * BIT_CLK + BIT_CLK / 2);
      rst = 1'b0;
      idle(3);
      test_reset();
      idle(50);
      clear_mon();
      rst = 1'b1;
      idle(800);
      send_frame(8'hFF, BIT_CLK, 1'b1, BIT_CLK);
      idle(300);
      check_count("rstmid_done_count", got_q.size(), 1);
      vectors++;
      if (got_at(0) !== 8'hFF) begin
         miscompares++;
         $display("FAIL rstmid_data: got %h expected ff", got_at(0));
      end
      check_count("rstmid_ferr_count", ferr_cnt, 0);
   endtask

   task automatic test_baud_tolerance();
      clear_mon();
      send_frame(8'hA5, 157, 1'b1, 157);
      idle(200);
      send_frame(8'h3C, 163, 1'b1, 163);
      idle(300);
      check_count("tol_done_count", got_q.size(), 2);
      vectors++;
      if (got_at(0) !== 8'hA5) begin
         miscompares++;
         $display("FAIL tol_fast_data: got %h expected a5", got_at(0));
      end
      vectors++;
      if (got_at(1) !== 8'h3C) begin
         miscompares++;
         $display("FAIL tol_slow_data: got %h expected 3c", got_at(1));
      end
      check_count("tol_ferr_count", ferr_cnt, 0);
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      int         exp_ferr;
      logic [7:0] b;
      int         bclk;
      logic       bad;
      exp_ferr = 0;
      clear_mon();
      for (int k = 0; k < 12; k++) begin
         b    = 8'($urandom);
         bclk = int'($urandom_range(157, 163));
         bad  = ($urandom_range(0, 5) == 0);
         if (bad) begin
            send_frame(b, bclk, 1'b0, BAD_STOP_END - 9 * bclk);
            exp_ferr++;
            idle(100 + int'($urandom_range(0, 100)));
         end else begin
            send_frame(b, bclk, 1'b1, bclk);
            exp_q.push_back(b);
            idle(int'($urandom_range(0, 200)));
         end
      end
      idle(400);
      check_count("rand_done_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         vectors++;
         if (got_at(i) !== exp_q[i]) begin
            miscompares++;
            $display("FAIL rand_data[%0d]: got %h expected %h", i, got_at(i), exp_q[i]);
         end
      end
      check_count("rand_ferr_count", ferr_cnt, exp_ferr);
   endtask

   task automatic test_pulse_shape();
      check_count("pulse_overlap", overlap, 0);
      check_count("pulse_width", wide, 0);
   endtask

   initial begin
      rst  = 1'b0;
      i_rx = 1'b1;
      @(negedge clk);
      idle(5);
      test_reset();
      rst = 1'b1;
      idle(20);
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_midframe();
      test_baud_tolerance();
      test_random();
      test_pulse_shape();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
